sha512_padder: RTL and testbench

SHA512_PADDER -- requirements
Module: sha512_padder

---
 rtl/sha512_pkg.sv | 24 ++
 rtl/sha512_padder_if.sv | 32 +++
 rtl/sha512_pad_word.sv | 22 ++
 rtl/sha512_padder.sv | 146 ++++++++++++++
 tb/tb_sha512_padder.sv | 393 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sha512_pkg.sv
// SHA-512 padder shared definitions.
// Chunk geometry, padder states and beat-size clamp.
package sha512_pkg;

  localparam int CHUNK_BITS = 1024;
  localparam int WORD_BITS = 64;
  localparam int WORDS_PER_CHUNK = 16;
  localparam int LEN_BITS = 128;

  typedef enum logic [1:0] {
    FILL,
    EMIT,
    EMIT_EXTRA
  } padState_e;

  function automatic logic [3:0] clampBytes(
    input logic last,
    input logic [3:0] bytes
  );
    if (!last) return 4'd8;
    return (bytes > 4'd8) ? 4'd8 : bytes;
  endfunction

endpackage

// File: rtl/sha512_padder_if.sv
// SHA-512 padder stream interface.
// Beat input, chunk output and status.
interface sha512_padder_if;
  import sha512_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [WORD_BITS-1:0]  in_data;
  logic                  in_last;
  logic [3:0]            in_bytes;
  logic                  out_valid;
  logic                  out_ready;
  logic [CHUNK_BITS-1:0] out_chunk;
  logic                  out_first;
  logic                  out_last;
  logic                  busy;

  modport slave (
    input  in_valid, in_data, in_last,
    input  in_bytes, out_ready,
    output in_ready, out_valid, out_chunk,
    output out_first, out_last, busy
  );

  modport master (
    output in_valid, in_data, in_last,
    output in_bytes, out_ready,
    input  in_ready, out_valid, out_chunk,
    input  out_first, out_last, busy
  );

endinterface

// File: rtl/sha512_pad_word.sv
// Masks a beat to its valid bytes and inserts
// the 0x80 marker just past them.
module sha512_pad_word
  import sha512_pkg::*;
(
  input  logic [WORD_BITS-1:0] word,
  input  logic [3:0]           nBytes,
  input  logic                 placeMarker,
  output logic [WORD_BITS-1:0] padded
);

  always_comb begin
    padded = '0;
    for (int k = 0; k < 8; k++) begin
      if (4'(k) < nBytes)
        padded[63-8*k -: 8] = word[63-8*k -: 8];
      else if (4'(k) == nBytes && placeMarker)
        padded[63-8*k -: 8] = 8'h80;
    end
  end

endmodule

// File: rtl/sha512_padder.sv
// SHA-512 message padder: packs 64-bit beats
// into 1024-bit chunks with marker and length.
module sha512_padder
  import sha512_pkg::*;
(
  input logic clk,
  input logic reset,
  sha512_padder_if.slave bus
);

  padState_e state, stateNext;

  logic [3:0]            w;
  logic [63:0]           byteCount;
  logic [CHUNK_BITS-1:0] chunk;
  logic                  firstPend;
  logic                  outFirst;
  logic                  outLast;
  logic                  needExtra;
  logic                  extraMarker;
  logic                  busyQ;

  logic                  accept;
  logic [3:0]            nBytes;
  logic [7:0]            pos;
  logic [63:0]           countNext;
  logic                  lenFits;
  logic [WORD_BITS-1:0]  padWord;
  logic [CHUNK_BITS-1:0] beatChunk;
  logic [CHUNK_BITS-1:0] extraChunk;

  assign accept = (state == FILL) && bus.in_valid;
  assign nBytes = clampBytes(bus.in_last, bus.in_bytes);
  assign pos = {1'b0, w, 3'b000} + {4'd0, nBytes};
  assign countNext = byteCount + {60'd0, nBytes};
  assign lenFits = pos <= 8'd111;

  sha512_pad_word uPad (
    .word        (bus.in_data),
    .nBytes      (nBytes),
    .placeMarker (bus.in_last),
    .padded      (padWord)
  );

  // Final beat also clears the stale tail of the chunk
  always_comb begin
    beatChunk = chunk;
    for (int j = 0; j < WORDS_PER_CHUNK; j++) begin
      if (4'(j) == w)
        beatChunk[CHUNK_BITS-1-WORD_BITS*j -: WORD_BITS] = padWord;
      else if (bus.in_last && 4'(j) > w)
        beatChunk[CHUNK_BITS-1-WORD_BITS*j -: WORD_BITS] =
          (nBytes == 4'd8 && 4'(j) == w + 4'd1) ?
          64'h8000_0000_0000_0000 : 64'd0;
    end
    if (bus.in_last && lenFits)
      beatChunk[LEN_BITS-1:0] = {61'd0, countNext, 3'b000};
  end

  always_comb begin
    extraChunk = '0;
    extraChunk[CHUNK_BITS-1 -: 8] = extraMarker ? 8'h80 : 8'h00;
    extraChunk[LEN_BITS-1:0] = {61'd0, byteCount, 3'b000};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FILL;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      FILL:
        if (accept && (bus.in_last || w == 4'd15))
          stateNext = EMIT;
      EMIT:
        if (bus.out_ready)
          stateNext = needExtra ? EMIT_EXTRA : FILL;
      EMIT_EXTRA:
        if (bus.out_ready) stateNext = FILL;
      default: stateNext = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w           <= '0;
      byteCount   <= '0;
      chunk       <= '0;
      firstPend   <= 1'b1;
      outFirst    <= 1'b0;
      outLast     <= 1'b0;
      needExtra   <= 1'b0;
      extraMarker <= 1'b0;
      busyQ       <= 1'b0;
    end else begin
      unique case (state)
        FILL:
          if (accept) begin
            busyQ     <= 1'b1;
            chunk     <= beatChunk;
            byteCount <= countNext;
            if (bus.in_last || w == 4'd15) begin
              w         <= '0;
              outFirst  <= firstPend;
              firstPend <= 1'b0;
              outLast   <= bus.in_last && lenFits;
              needExtra <= bus.in_last && !lenFits;
              extraMarker <= bus.in_last && pos == 8'd128;
            end else begin
              w <= w + 4'd1;
            end
          end
        EMIT:
          if (bus.out_ready) begin
            if (needExtra) begin
              chunk     <= extraChunk;
              outFirst  <= 1'b0;
              outLast   <= 1'b1;
              needExtra <= 1'b0;
            end else if (outLast) begin
              byteCount <= '0;
              firstPend <= 1'b1;
              busyQ     <= 1'b0;
            end
          end
        EMIT_EXTRA:
          if (bus.out_ready) begin
            byteCount <= '0;
            firstPend <= 1'b1;
            busyQ     <= 1'b0;
          end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == FILL);
  assign bus.out_valid = (state != FILL);
  assign bus.out_chunk = chunk;
  assign bus.out_first = outFirst;
  assign bus.out_last  = outLast;
  assign bus.busy      = busyQ;

endmodule

// File: tb/tb_sha512_padder.sv
// Bench for sha512_padder: random messages vs
// a byte-stream padding model.
module tb_sha512_padder;
  import sha512_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  sha512_padder_if bus ();

  sha512_padder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int nChecks = 0;
  int nFails = 0;

  logic [1023:0] obsChunk[$];
  bit            obsFirst[$];
  bit            obsLast[$];
  logic [1023:0] expChunk[$];
  bit            runTimeout;

  // Standard SHA-512 padding on a byte stream
  function automatic void build_expected(input byte unsigned msg[$]);
    byte unsigned pad[$];
    logic [127:0] bits;
    logic [1023:0] c;
    pad = msg;
    bits = {61'd0, 64'(msg.size()), 3'b000};
    pad.push_back(8'h80);
    while (pad.size() % 128 != 112) pad.push_back(8'h00);
    for (int i = 0; i < 16; i++) pad.push_back(bits[127-8*i -: 8]);
    expChunk.delete();
    for (int k = 0; k < pad.size() / 128; k++) begin
      c = '0;
      for (int i = 0; i < 128; i++) c[1023-8*i -: 8] = pad[128*k+i];
      expChunk.push_back(c);
    end
  endfunction

  task automatic drive_msg(input byte unsigned msg[$], input bit zeroTail,
                           input int idlePct);
    int L, nb, lastN, n, t;
    logic [63:0] d;
    L = msg.size();
    if (L > 0 && L % 8 == 0 && !zeroTail) begin
      nb = L / 8; lastN = 8;
    end else begin
      nb = L / 8 + 1; lastN = L % 8;
    end
    for (int b = 0; b < nb && !runTimeout; b++) begin
      n = (b == nb - 1) ? lastN : 8;
      d = {$urandom, $urandom};
      for (int i = 0; i < n; i++) d[63-8*i -: 8] = msg[8*b+i];
      while ($urandom_range(0, 99) < idlePct) begin
        bus.in_valid = 1'b0;
        @(negedge clk);
      end
      bus.in_valid = 1'b1;
      bus.in_data = d;
      bus.in_last = (b == nb - 1);
      if (b != nb - 1) bus.in_bytes = 4'($urandom_range(0, 15));
      else if (n == 8) bus.in_bytes = 4'($urandom_range(8, 15));
      else bus.in_bytes = 4'(n);
      t = 0;
      while (!bus.in_ready && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (t >= 200) runTimeout = 1'b1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic collect(input int stallPct);
    int t;
    bit done;
    t = 0;
    done = 1'b0;
    while (!done && t < 800) begin
      bus.out_ready = ($urandom_range(0, 99) >= stallPct);
      if (bus.out_valid && bus.out_ready) begin
        obsChunk.push_back(bus.out_chunk);
        obsFirst.push_back(bus.out_first);
        obsLast.push_back(bus.out_last);
        if (bus.out_last) done = 1'b1;
      end
      @(negedge clk);
      t++;
    end
    bus.out_ready = 1'b0;
    if (!done) runTimeout = 1'b1;
  endtask

  task automatic run_msg(input byte unsigned msg[$], input bit zeroTail,
                         input int idlePct, input int stallPct);
    runTimeout = 1'b0;
    obsChunk.delete();
    obsFirst.delete();
    obsLast.delete();
    build_expected(msg);
    fork
      drive_msg(msg, zeroTail, idlePct);
      collect(stallPct);
    join
  endtask

  task automatic put_beat(input logic [63:0] d, input bit last,
                          input logic [3:0] nb, output bit ok);
    int t;
    bus.in_valid = 1'b1;
    bus.in_data = d;
    bus.in_last = last;
    bus.in_bytes = nb;
    t = 0;
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    ok = (t < 50);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_last = 1'b0;
    bus.in_bytes = '0;
    bus.out_ready = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    nChecks++;
    if (bus.out_valid !== 1'b0) begin
      nFails++;
      $display("FAIL reset_valid_in_reset got %b exp 0", bus.out_valid);
    end
    reset = 1'b1;
    nChecks++;
    if (bus.in_ready !== 1'b1) begin
      nFails++;
      $display("FAIL reset_in_ready got %b exp 1", bus.in_ready);
    end
    nChecks++;
    if (bus.out_valid !== 1'b0) begin
      nFails++;
      $display("FAIL reset_out_valid got %b exp 0", bus.out_valid);
    end
    nChecks++;
    if (bus.busy !== 1'b0) begin
      nFails++;
      $display("FAIL reset_busy got %b exp 0", bus.busy);
    end
    nChecks++;
    if (bus.out_first !== 1'b0 || bus.out_last !== 1'b0) begin
      nFails++;
      $display("FAIL reset_flags got %b%b exp 00", bus.out_first, bus.out_last);
    end
    nChecks++;
    if (bus.out_chunk !== '0) begin
      nFails++;
      $display("FAIL reset_chunk got nonzero exp 0");
    end
  endtask

  task automatic test_vectors();
    int lens[9] = '{0, 3, 111, 112, 128, 128, 55, 56, 8};
    bit zt[9] = '{0, 0, 0, 0, 0, 1, 0, 0, 1};
    byte unsigned msg[$];
    logic [1023:0] oc, ec;
    logic [63:0] w0, w15;
    int wd;
    for (int v = 0; v < 9; v++) begin
      msg.delete();
      if (v == 1) msg = '{8'h61, 8'h62, 8'h63};
      else for (int i = 0; i < lens[v]; i++) msg.push_back(8'($urandom));
      run_msg(msg, zt[v], 20, 30);
      nChecks++;
      if (runTimeout) begin
        nFails++;
        $display("FAIL vec%0d timeout got 1 exp 0", v);
      end
      nChecks++;
      if (obsChunk.size() != expChunk.size()) begin
        nFails++;
        $display("FAIL vec%0d chunk_count got %0d exp %0d", v,
                 obsChunk.size(), expChunk.size());
      end
      for (int k = 0; k < obsChunk.size() && k < expChunk.size(); k++) begin
        oc = obsChunk[k];
        ec = expChunk[k];
        nChecks++;
        if (oc !== ec) begin
          wd = 0;
          while (wd < 15 && oc[1023-64*wd -: 64] === ec[1023-64*wd -: 64]) wd++;
          nFails++;
          $display("FAIL vec%0d chunk%0d word%0d got %h exp %h", v, k, wd,
                   oc[1023-64*wd -: 64], ec[1023-64*wd -: 64]);
        end
        nChecks++;
        if (obsFirst[k] !== (k == 0)) begin
          nFails++;
          $display("FAIL vec%0d first%0d got %b exp %b", v, k, obsFirst[k], k == 0);
        end
        nChecks++;
        if (obsLast[k] !== (k == expChunk.size() - 1)) begin
          nFails++;
          $display("FAIL vec%0d last%0d got %b exp %b", v, k, obsLast[k],
                   k == expChunk.size() - 1);
        end
      end
      if (obsChunk.size() > 0) begin
        oc = obsChunk[obsChunk.size()-1];
        w0 = oc[1023:960];
        w15 = oc[63:0];
        nChecks++;
        if (w15 !== 64'(8 * lens[v])) begin
          nFails++;
          $display("FAIL vec%0d len_word got %h exp %h", v, w15, 64'(8 * lens[v]));
        end
        if (v == 0 || v == 4 || v == 5) begin
          nChecks++;
          if (w0 !== 64'h8000_0000_0000_0000) begin
            nFails++;
            $display("FAIL vec%0d word0 got %h exp 8000000000000000", v, w0);
          end
        end
        if (v == 1) begin
          nChecks++;
          if (w0 !== 64'h6162_6380_0000_0000) begin
            nFails++;
            $display("FAIL abc_word0 got %h exp 6162638000000000", w0);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    byte unsigned msg[$];
    logic [1023:0] oc, ec;
    int len, wd;
    for (int m = 0; m < 20; m++) begin
      msg.delete();
      len = $urandom_range(0, 300);
      for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
      run_msg(msg, 1'($urandom), $urandom_range(0, 40), $urandom_range(0, 50));
      nChecks++;
      if (runTimeout) begin
        nFails++;
        $display("FAIL rand%0d timeout got 1 exp 0", m);
      end
      nChecks++;
      if (obsChunk.size() != expChunk.size()) begin
        nFails++;
        $display("FAIL rand%0d chunk_count got %0d exp %0d", m,
                 obsChunk.size(), expChunk.size());
      end
      for (int k = 0; k < obsChunk.size() && k < expChunk.size(); k++) begin
        oc = obsChunk[k];
        ec = expChunk[k];
        nChecks++;
        if (oc !== ec) begin
          wd = 0;
          while (wd < 15 && oc[1023-64*wd -: 64] === ec[1023-64*wd -: 64]) wd++;
          nFails++;
          $display("FAIL rand%0d chunk%0d word%0d got %h exp %h", m, k, wd,
                   oc[1023-64*wd -: 64], ec[1023-64*wd -: 64]);
        end
        nChecks++;
        if (obsFirst[k] !== (k == 0) || obsLast[k] !== (k == expChunk.size() - 1)) begin
          nFails++;
          $display("FAIL rand%0d flags%0d got %b%b exp %b%b", m, k, obsFirst[k],
                   obsLast[k], k == 0, k == expChunk.size() - 1);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    byte unsigned msg[$];
    logic [1023:0] held;
    bit ok;
    msg = '{8'h61, 8'h62, 8'h63};
    build_expected(msg);
    put_beat(64'h6162_63a5_5a5a_5a5a, 1'b1, 4'd3, ok);
    nChecks++;
    if (!ok || bus.out_valid !== 1'b1) begin
      nFails++;
      $display("FAIL bp_valid got %b exp 1", bus.out_valid);
    end
    held = bus.out_chunk;
    nChecks++;
    if (held !== expChunk[0]) begin
      nFails++;
      $display("FAIL bp_chunk got %h exp %h", held[1023:960], expChunk[0][1023:960]);
    end
    bus.in_valid = 1'b1;
    bus.in_data = {$urandom, $urandom};
    bus.in_last = 1'b1;
    bus.in_bytes = 4'd8;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      nChecks++;
      if (bus.out_chunk !== held || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          bus.busy !== 1'b1) begin
        nFails++;
        $display("FAIL bp_stall%0d got v%b r%b b%b exp v1 r0 b1", c,
                 bus.out_valid, bus.in_ready, bus.busy);
      end
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    nChecks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      nFails++;
      $display("FAIL bp_after got v%b r%b b%b exp v0 r1 b0", bus.out_valid,
               bus.in_ready, bus.busy);
    end
  endtask

  task automatic test_reset_mid();
    byte unsigned msg[$];
    logic [1023:0] oc, ec;
    bit ok, allOk;
    allOk = 1'b1;
    for (int b = 0; b < 16; b++) begin
      put_beat({$urandom, $urandom}, 1'b0, 4'($urandom_range(0, 15)), ok);
      allOk &= ok;
    end
    nChecks++;
    if (!allOk || bus.out_valid !== 1'b1 || bus.out_last !== 1'b0) begin
      nFails++;
      $display("FAIL rm_emit got v%b l%b exp v1 l0", bus.out_valid, bus.out_last);
    end
    #2 reset = 1'b0;
    #1;
    nChecks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      nFails++;
      $display("FAIL rm_async got v%b b%b r%b exp v0 b0 r1", bus.out_valid,
               bus.busy, bus.in_ready);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int b = 0; b < 3; b++) put_beat({$urandom, $urandom}, 1'b0, 4'd8, ok);
    #2 reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    msg.delete();
    for (int i = 0; i < 20; i++) msg.push_back(8'($urandom));
    run_msg(msg, 1'b0, 0, 0);
    nChecks++;
    if (runTimeout || obsChunk.size() != 1) begin
      nFails++;
      $display("FAIL rm_count got %0d exp 1", obsChunk.size());
    end
    if (obsChunk.size() > 0) begin
      oc = obsChunk[0];
      ec = expChunk[0];
      nChecks++;
      if (oc !== ec) begin
        nFails++;
        $display("FAIL rm_chunk got %h_%h exp %h_%h", oc[1023:960], oc[63:0],
                 ec[1023:960], ec[63:0]);
      end
      nChecks++;
      if (obsFirst[0] !== 1'b1 || obsLast[0] !== 1'b1) begin
        nFails++;
        $display("FAIL rm_flags got %b%b exp 11", obsFirst[0], obsLast[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end

endmodule
